// File: rtl/control_sequencer.sv
// Command decoder and INTA sequencer for an 8259-style interrupt controller.
// Define AUTO_EOI_EN to enable automatic EOI at the end of the INTA cycle when icw4[1] is set.
module control_sequencer #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             a0,
  input  logic [7:0]       command_word,
  input  logic             inta,
  input  logic [N_IRQ-1:0] isr,
  input  logic             send_vector_address,
  output logic [7:0]       vector_address,
  output logic             direction,
  output logic [1:0]       number_of_ack,
  output logic [7:0]       icw3,
  output logic [7:0]       icw4,
  output logic [7:0]       ocw1,
  output logic [7:0]       ocw3,
  output logic             init_done,
  output logic             eoi_pulse,
  output logic [N_IRQ-1:0] eoi_vec
);

  localparam int IDX_W = $clog2(N_IRQ);
  localparam logic [N_IRQ-1:0] ONE_HOT_BASE = {{(N_IRQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} icw_state_t;

  icw_state_t       state, state_next;
  logic             icw1_sngl, icw1_ic4;
  logic [7-IDX_W:0] icw2_base;
  logic             inta_q;
  logic [IDX_W-1:0] idx;
  logic             load_icw1, load_icw2, load_icw3, load_icw4, finish_init;
  logic             load_ocw1, load_ocw2, load_ocw3;
  logic             ocw2_eoi, auto_eoi, any_eoi, inta_rise, inta_fall;
  logic [N_IRQ-1:0] eoi_sel;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ICW1 wins from any state; otherwise each write advances the ICW sequence by one step.
  always_comb begin
    state_next  = state;
    load_icw1   = 1'b0;
    load_icw2   = 1'b0;
    load_icw3   = 1'b0;
    load_icw4   = 1'b0;
    finish_init = 1'b0;
    load_ocw1   = 1'b0;
    load_ocw2   = 1'b0;
    load_ocw3   = 1'b0;
    if (wr && !a0 && command_word[4]) begin
      load_icw1  = 1'b1;
      state_next = WAIT_ICW2;
    end else if (wr) begin
      case (state)
        WAIT_ICW2: begin
          load_icw2 = 1'b1;
          if (!icw1_sngl)   state_next = WAIT_ICW3;
          else if (icw1_ic4) state_next = WAIT_ICW4;
          else begin
            state_next  = IDLE;
            finish_init = 1'b1;
          end
        end
        WAIT_ICW3: begin
          load_icw3 = 1'b1;
          if (icw1_ic4) state_next = WAIT_ICW4;
          else begin
            state_next  = IDLE;
            finish_init = 1'b1;
          end
        end
        WAIT_ICW4: begin
          load_icw4   = 1'b1;
          state_next  = IDLE;
          finish_init = 1'b1;
        end
        default: begin
          if (init_done) begin
            if (a0)                   load_ocw1 = 1'b1;
            else if (!command_word[3]) load_ocw2 = 1'b1;
            else                      load_ocw3 = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (isr[i]) idx = IDX_W'(i);
    end
  end

  assign inta_rise = inta & ~inta_q;
  assign inta_fall = ~inta & inta_q;
  assign ocw2_eoi  = load_ocw2 & command_word[5];

`ifdef AUTO_EOI_EN
  assign auto_eoi = icw4[1] & inta_fall & (number_of_ack == 2'd2);
`else
  assign auto_eoi = 1'b0;
`endif

  assign any_eoi = ocw2_eoi | auto_eoi;

  // Specific EOI names its channel; otherwise clear the highest-priority in-service one.
  always_comb begin
    eoi_sel = '0;
    if (ocw2_eoi && command_word[6]) eoi_sel = ONE_HOT_BASE << command_word[IDX_W-1:0];
    else if (|isr)                   eoi_sel = ONE_HOT_BASE << idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icw1_sngl     <= 1'b0;
      icw1_ic4      <= 1'b0;
      icw2_base     <= '0;
      icw3          <= 8'h00;
      icw4          <= 8'h00;
      ocw1          <= 8'h00;
      ocw3          <= 8'h00;
      init_done     <= 1'b0;
      eoi_pulse     <= 1'b0;
      eoi_vec       <= '0;
      inta_q        <= 1'b0;
      number_of_ack <= 2'd0;
    end else begin
      if (load_icw1) begin
        icw1_sngl <= command_word[1];
        icw1_ic4  <= command_word[0];
        icw3      <= 8'h00;
        icw4      <= 8'h00;
        ocw1      <= 8'h00;
        ocw3      <= 8'h00;
        init_done <= 1'b0;
      end
      if (load_icw2)   icw2_base <= command_word[7:IDX_W];
      if (load_icw3)   icw3      <= command_word;
      if (load_icw4)   icw4      <= command_word;
      if (finish_init) init_done <= 1'b1;
      if (load_ocw1)   ocw1      <= command_word;
      if (load_ocw3)   ocw3      <= command_word;
      eoi_pulse <= any_eoi;
      eoi_vec   <= any_eoi ? eoi_sel : '0;
      inta_q    <= inta;
      if (number_of_ack == 2'd2 && !inta)     number_of_ack <= 2'd0;
      else if (inta_rise && number_of_ack != 2'd2) number_of_ack <= number_of_ack + 2'd1;
    end
  end

  assign vector_address = {icw2_base, idx};
  assign direction      = (number_of_ack == 2'd2) & inta & send_vector_address;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (N_IRQ = 8).
// Auto-EOI expectations follow whether AUTO_EOI_EN is defined for the build.
module tb_control_sequencer;

  localparam int N_IRQ = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr = 1'b0;
  logic             a0 = 1'b0;
  logic [7:0]       command_word = 8'h00;
  logic             inta = 1'b0;
  logic [N_IRQ-1:0] isr = '0;
  logic             send_vector_address = 1'b0;
  logic [7:0]       vector_address;
  logic             direction;
  logic [1:0]       number_of_ack;
  logic [7:0]       icw3, icw4, ocw1, ocw3;
  logic             init_done;
  logic             eoi_pulse;
  logic [N_IRQ-1:0] eoi_vec;

  int checkCount = 0;
  int failCount  = 0;

`ifdef AUTO_EOI_EN
  localparam logic AUTO_ON = 1'b1;
`else
  localparam logic AUTO_ON = 1'b0;
`endif

  control_sequencer #(.N_IRQ(N_IRQ)) dut (
    .clk                 (clk),
    .reset               (reset),
    .wr                  (wr),
    .a0                  (a0),
    .command_word        (command_word),
    .inta                (inta),
    .isr                 (isr),
    .send_vector_address (send_vector_address),
    .vector_address      (vector_address),
    .direction           (direction),
    .number_of_ack       (number_of_ack),
    .icw3                (icw3),
    .icw4                (icw4),
    .ocw1                (ocw1),
    .ocw3                (ocw3),
    .init_done           (init_done),
    .eoi_pulse           (eoi_pulse),
    .eoi_vec             (eoi_vec)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One write strobe; returns on the falling edge after the sampling edge.
  task automatic applyStimulus(input logic addr, input logic [7:0] data);
    @(negedge clk);
    wr = 1'b1; a0 = addr; command_word = data;
    @(negedge clk);
    wr = 1'b0; a0 = 1'b0; command_word = 8'h00;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_icw3", icw3, 8'h00);
    checkOutput("rst_icw4", icw4, 8'h00);
    checkOutput("rst_ocw1", ocw1, 8'h00);
    checkOutput("rst_ack", number_of_ack, 0);
    checkOutput("rst_dir", direction, 0);
    checkOutput("rst_eoi", eoi_pulse, 0);
    checkOutput("rst_eoi_vec", eoi_vec, 8'h00);

    // ICW1 single, with ICW4
    applyStimulus(0, 8'h13);
    checkOutput("seq1_done_after_icw1", init_done, 0);
    applyStimulus(1, 8'h40);
    checkOutput("seq1_done_after_icw2", init_done, 0);
    applyStimulus(1, 8'h01);
    checkOutput("seq1_done", init_done, 1);
    checkOutput("seq1_icw4", icw4, 8'h01);
    checkOutput("seq1_icw3", icw3, 8'h00);
    isr = 8'h20; #1;
    checkOutput("seq1_vector", vector_address, 8'h45);

    // ICW1 restart mid-sequence
    applyStimulus(0, 8'h13);
    checkOutput("restart_done_cleared", init_done, 0);
    checkOutput("restart_icw4_cleared", icw4, 8'h00);
    applyStimulus(1, 8'h48);
    applyStimulus(0, 8'h13);
    checkOutput("restart_done_again", init_done, 0);
    applyStimulus(1, 8'h50);
    checkOutput("restart_still_waiting", init_done, 0);
    applyStimulus(1, 8'h03);
    checkOutput("restart_done", init_done, 1);
    checkOutput("restart_icw4", icw4, 8'h03);
    checkOutput("restart_vector", vector_address, 8'h55);
    isr = 8'h00; #1;
    checkOutput("vector_isr_zero", vector_address, 8'h50);
    isr = 8'h81; #1;
    checkOutput("vector_isr_low", vector_address, 8'h50);
    isr = 8'h80; #1;
    checkOutput("vector_isr_high", vector_address, 8'h57);

    // OCW1 / OCW3
    applyStimulus(1, 8'hA5);
    checkOutput("ocw1", ocw1, 8'hA5);
    applyStimulus(0, 8'h0B);
    checkOutput("ocw3", ocw3, 8'h0B);
    checkOutput("ocw3_keeps_ocw1", ocw1, 8'hA5);

    // OCW2 EOIs
    isr = 8'h0C;
    applyStimulus(0, 8'h20);
    checkOutput("nseoi_pulse", eoi_pulse, 1);
    checkOutput("nseoi_vec", eoi_vec, 8'h04);
    @(negedge clk);
    checkOutput("nseoi_one_cycle", eoi_pulse, 0);
    applyStimulus(0, 8'h63);
    checkOutput("seoi_pulse", eoi_pulse, 1);
    checkOutput("seoi_vec", eoi_vec, 8'h08);
    applyStimulus(0, 8'h40);
    checkOutput("no_eoi", eoi_pulse, 0);
    isr = 8'h00;
    applyStimulus(0, 8'h20);
    checkOutput("nseoi_empty_pulse", eoi_pulse, 1);
    checkOutput("nseoi_empty_vec", eoi_vec, 8'h00);

    // INTA sequence
    send_vector_address = 1'b1;
    isr = 8'h02;
    @(negedge clk); inta = 1'b1;
    @(negedge clk);
    checkOutput("ack_first", number_of_ack, 1);
    checkOutput("dir_first", direction, 0);
    inta = 1'b0;
    @(negedge clk);
    checkOutput("ack_hold", number_of_ack, 1);
    inta = 1'b1;
    @(negedge clk);
    checkOutput("ack_second", number_of_ack, 2);
    checkOutput("dir_second", direction, 1);
    send_vector_address = 1'b0; #1;
    checkOutput("dir_no_sva", direction, 0);
    send_vector_address = 1'b1; #1;
    inta = 1'b0; #1;
    checkOutput("dir_inta_low", direction, 0);
    @(negedge clk);
    checkOutput("ack_cleared", number_of_ack, 0);
    checkOutput("auto_eoi_pulse", eoi_pulse, AUTO_ON);
    checkOutput("auto_eoi_vec", eoi_vec, AUTO_ON ? 8'h02 : 8'h00);
    @(negedge clk);
    checkOutput("auto_eoi_one_cycle", eoi_pulse, 0);

    // Reset during WAIT_ICW3 with ack pending, colliding with a write
    isr = 8'h00;
    applyStimulus(0, 8'h10);
    applyStimulus(1, 8'h20);
    inta = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_ack", number_of_ack, 1);
    reset = 1'b1; inta = 1'b0;
    wr = 1'b1; a0 = 1'b0; command_word = 8'h13;
    @(negedge clk);
    reset = 1'b0; wr = 1'b0; command_word = 8'h00;
    checkOutput("post_reset_ack", number_of_ack, 0);
    checkOutput("post_reset_done", init_done, 0);
    checkOutput("post_reset_vector", vector_address, 8'h00);
    checkOutput("post_reset_eoi", eoi_pulse, 0);
    applyStimulus(1, 8'h04);
    checkOutput("post_reset_ignored_icw3", icw3, 8'h00);
    checkOutput("post_reset_ignored_ocw1", ocw1, 8'h00);
    checkOutput("post_reset_ignored_vector", vector_address, 8'h00);

    // Full four-word sequence, then cascade without ICW4
    applyStimulus(0, 8'h11);
    applyStimulus(1, 8'h20);
    applyStimulus(1, 8'h04);
    checkOutput("four_icw3", icw3, 8'h04);
    checkOutput("four_not_done", init_done, 0);
    applyStimulus(1, 8'h01);
    checkOutput("four_icw4", icw4, 8'h01);
    checkOutput("four_done", init_done, 1);
    applyStimulus(0, 8'h10);
    applyStimulus(1, 8'h20);
    applyStimulus(1, 8'h04);
    checkOutput("three_done", init_done, 1);
    checkOutput("three_icw3", icw3, 8'h04);
    checkOutput("three_icw4", icw4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
